s2p_deserializer: RTL

// - Serial-to-parallel receiver. Samples one serial bit per enabled clock and assembles WIDTH-bit words.
// - Presents each completed word with a one-cycle o_valid strobe.
// - Sits at the receive end of the LSB-first serial link driven by the team's parallel-to-serial transmitter.
//

---
 rtl/s2p_pkg.sv | 8 +
 rtl/s2p_deserializer.sv | 47 ++++
 2 files changed

// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and helpers for the serial-to-parallel receiver
package s2p_pkg;
  localparam int S2P_WIDTH_DEFAULT = 16;
  typedef enum logic {S2P_IDLE, S2P_SHIFT} s2p_state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/s2p_deserializer.sv
// s2p_deserializer: assembles WIDTH-bit words from enabled serial bits, strobes o_valid per word
module s2p_deserializer
  import s2p_pkg::*;
#(
  parameter int WIDTH     = S2P_WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_S2P,
  input  logic             i_sync,
  output logic [WIDTH-1:0] o_S2P,
  output logic             o_valid,
  output logic             o_busy
);
  localparam int CNT_W = cnt_w(WIDTH);
  s2p_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] sr, sr_next, base, shifted;
  logic last;
  // i_sync clears the partial word before the current bit (if any) is shifted in
  always_comb begin
    base       = i_sync ? '0 : sr;
    shifted    = LSB_FIRST ? {i_S2P, base[WIDTH-1:1]} : {base[WIDTH-2:0], i_S2P};
    sr_next    = i_enable ? shifted : base;
    last       = i_enable && !i_sync && (cnt == CNT_W'(WIDTH - 1));
    cnt_next   = i_enable ? (i_sync ? CNT_W'(1) : (last ? '0 : cnt + 1'b1)) : (i_sync ? '0 : cnt);
    state_next = (cnt_next != '0) ? S2P_SHIFT : S2P_IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S2P_IDLE;
      cnt     <= '0;
      sr      <= '0;
      o_S2P   <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      sr      <= sr_next;
      o_valid <= last;
      if (last) o_S2P <= shifted;
    end
  end
  assign o_busy = (state == S2P_SHIFT);
endmodule
